pic_prefetch_fifo: RTL and testbench

Picture-path buffer directly upstream of the RGB timing generator.
- Accepts 48-bit two-pixel words from the memory read engine over a valid/ready handshake.
- Primes a fill level at each frame start, then raises pic_rdy.
- Serves pic_fifo_rd pops, with pic_data valid one cycle after the pop.
- Flags and substitutes a fixed colour on underflow.

---
 rtl/pic_prefetch_fifo_pkg.sv | 29 ++
 rtl/pic_prefetch_fifo_if.sv | 22 ++
 rtl/pic_prefetch_fifo_ram.sv | 24 ++
 rtl/pic_prefetch_fifo.sv | 142 ++++++++++++++
 tb/tb_pic_prefetch_fifo.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pic_prefetch_fifo_pkg.sv
// Shared types and helpers for the picture prefetch FIFO: pixel word width,
// FSM state encoding and the CRC-16-CCITT word fold.
package pic_fifo_pkg;

   localparam int PIX_W = 48;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLUSH  = 2'd1,
      PRIME  = 2'd2,
      STREAM = 2'd3
   } state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // Folds one whole pixel word into the CRC, most significant bit first.
   function automatic logic [15:0] crc16_w48(input logic [15:0] crc_in,
                                             input logic [PIX_W-1:0] data);
      logic [15:0] c;
      c = crc_in;
      for (int i = PIX_W - 1; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
         else                 c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/pic_prefetch_fifo_if.sv
// Write handshake from the memory read engine and pop/data path toward the
// RGB timing generator, bundled for the prefetch FIFO.
interface pic_prefetch_fifo_if;
   import pic_fifo_pkg::*;

   logic             wr_vld;
   logic [PIX_W-1:0] wr_data;
   logic             wr_rdy;
   logic             pic_fifo_rd;
   logic [PIX_W-1:0] pic_data;
   logic             pic_rdy;

   modport slave (
      input  wr_vld, wr_data, pic_fifo_rd,
      output wr_rdy, pic_data, pic_rdy
   );

   modport master (
      output wr_vld, wr_data, pic_fifo_rd,
      input  wr_rdy, pic_data, pic_rdy
   );
endinterface

// File: rtl/pic_prefetch_fifo_ram.sv
// Simple dual-port synchronous RAM for the FIFO storage; read data is
// registered and only updates when a read is enabled.
module pic_fifo_ram #(
   parameter int DEPTH = 1024,
   parameter int W     = 48
) (
   input  logic                     clk,
   input  logic                     i_wr_en,
   input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  logic [W-1:0]             i_wr_data,
   input  logic                     i_rd_en,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output logic [W-1:0]             o_rd_data
);
   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   always_ff @(posedge clk) begin
      if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
   end
endmodule

// File: rtl/pic_prefetch_fifo.sv
// Picture prefetch FIFO: primes to PRIME_LVL each frame, serves pops with one
// cycle latency and substitutes UNDERFLOW_PIX on empty pops. PIC_FIFO_CRC_EN adds a per-frame CRC.
module pic_prefetch_fifo
   import pic_fifo_pkg::*;
#(
   parameter int               DEPTH         = 1024,
   parameter int               PRIME_LVL     = 512,
   parameter logic [PIX_W-1:0] UNDERFLOW_PIX = 48'h0000FF_0000FF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pic_en,
   input  logic                   frame_start,
   pic_prefetch_fifo_if.slave     bus,
   output logic [$clog2(DEPTH):0] level,
   output logic                   underflow,
   output logic [15:0]            underflow_cnt,
   output logic [15:0]            frame_crc
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   state_t           r_state, w_state_next;
   logic [PW-1:0]    r_wr_ptr, r_rd_ptr, r_level;
   logic [PW-1:0]    w_wr_ptr_next, w_rd_ptr_next;
   logic             w_active, w_empty, w_full, w_push, w_rd_req, w_pop, w_uflow;
   logic             r_src_ram;
   logic [PIX_W-1:0] r_pic_hold, w_ram_q, w_pic_data;
   logic             r_underflow;
   logic [15:0]      r_underflow_cnt;

   assign w_active = (r_state == PRIME) || (r_state == STREAM);
   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_push   = bus.wr_vld && w_active && !w_full;
   assign w_rd_req = bus.pic_fifo_rd && w_active;
   assign w_pop    = w_rd_req && !w_empty;
   assign w_uflow  = w_rd_req && w_empty;

   always_comb begin
      w_state_next = r_state;
      if (!pic_en) begin
         w_state_next = IDLE;
      end else if (frame_start) begin
         w_state_next = FLUSH;
      end else begin
         case (r_state)
            FLUSH:   w_state_next = PRIME;
            PRIME:   if (r_level >= PW'(PRIME_LVL)) w_state_next = STREAM;
            default: w_state_next = r_state;
         endcase
      end
   end

   // Leaving the active states (disable or a new frame) discards buffered words.
   always_comb begin
      w_wr_ptr_next = r_wr_ptr + PW'(w_push);
      w_rd_ptr_next = r_rd_ptr + PW'(w_pop);
      if (w_state_next == IDLE || w_state_next == FLUSH) begin
         w_wr_ptr_next = '0;
         w_rd_ptr_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= IDLE;
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_level         <= '0;
         r_src_ram       <= 1'b0;
         r_pic_hold      <= '0;
         r_underflow     <= 1'b0;
         r_underflow_cnt <= '0;
      end else begin
         r_state  <= w_state_next;
         r_wr_ptr <= w_wr_ptr_next;
         r_rd_ptr <= w_rd_ptr_next;
         r_level  <= w_wr_ptr_next - w_rd_ptr_next;
         // Output source: RAM read register after a pop, hold register after an underflow.
         if (w_pop) begin
            r_src_ram <= 1'b1;
         end else if (w_uflow) begin
            r_src_ram  <= 1'b0;
            r_pic_hold <= UNDERFLOW_PIX;
         end
         if (w_state_next == FLUSH) begin
            r_underflow     <= 1'b0;
            r_underflow_cnt <= '0;
         end else if (w_uflow) begin
            r_underflow <= 1'b1;
            if (r_underflow_cnt != 16'hFFFF) r_underflow_cnt <= r_underflow_cnt + 16'd1;
         end
      end
   end

   pic_fifo_ram #(
      .DEPTH (DEPTH),
      .W     (PIX_W)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr[AW-1:0]),
      .i_wr_data (bus.wr_data),
      .i_rd_en   (w_pop),
      .i_rd_addr (r_rd_ptr[AW-1:0]),
      .o_rd_data (w_ram_q)
   );

   assign w_pic_data    = r_src_ram ? w_ram_q : r_pic_hold;
   assign bus.pic_data  = w_pic_data;
   assign bus.wr_rdy    = w_active && !w_full;
   assign bus.pic_rdy   = (r_state == STREAM);
   assign level         = r_level;
   assign underflow     = r_underflow;
   assign underflow_cnt = r_underflow_cnt;

`ifdef PIC_FIFO_CRC_EN
   logic        r_prod;
   logic [15:0] r_crc, r_frame_crc, w_crc_next;

   // A word produced this cycle is folded in before a same-cycle frame capture.
   assign w_crc_next = r_prod ? crc16_w48(r_crc, w_pic_data) : r_crc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prod      <= 1'b0;
         r_crc       <= CRC_INIT;
         r_frame_crc <= '0;
      end else begin
         r_prod <= w_pop || w_uflow;
         if (frame_start) r_frame_crc <= w_crc_next;
         r_crc <= (w_state_next == FLUSH) ? CRC_INIT : w_crc_next;
      end
   end

   assign frame_crc = r_frame_crc;
`else
   assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_pic_prefetch_fifo.sv
// Scoreboard bench for pic_prefetch_fifo (DEPTH=16, PRIME_LVL=8): directed
// pushes/pops queue expected words; a monitor checks pic_data one cycle after each pop.
module tb_pic_prefetch_fifo;
   localparam int          DEPTH     = 16;
   localparam int          PRIME_LVL = 8;
   localparam logic [47:0] UFLOW     = 48'h0000FF_0000FF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pic_en = 1'b0;
   logic        frame_start = 1'b0;
   logic [4:0]  level;
   logic        underflow;
   logic [15:0] underflow_cnt;
   logic [15:0] frame_crc;

   int          checks = 0;
   int          errors = 0;
   logic [47:0] exp_q[$];
   logic [15:0] model_crc = 16'hFFFF;
   logic [15:0] exp_fcrc;

   pic_prefetch_fifo_if bus();

   pic_prefetch_fifo #(
      .DEPTH         (DEPTH),
      .PRIME_LVL     (PRIME_LVL),
      .UNDERFLOW_PIX (UFLOW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pic_en        (pic_en),
      .frame_start   (frame_start),
      .bus           (bus),
      .level         (level),
      .underflow     (underflow),
      .underflow_cnt (underflow_cnt),
      .frame_crc     (frame_crc)
   );

   always #5 clk = ~clk;

   // Reference CRC-16-CCITT: shift the word out of its top bit, 48 times.
   function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [47:0] d);
      logic [15:0] r;
      logic [47:0] s;
      logic        fb;
      r = c;
      s = d;
      repeat (48) begin
         fb = r[15] ^ s[47];
         r  = r << 1;
         s  = s << 1;
         if (fb) r = r ^ 16'h1021;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end else begin
         $display("ok   %s = %h", nm, act);
      end
   endtask

   task automatic push(input logic [47:0] d);
      int n;
      n = 0;
      bus.wr_vld  = 1'b1;
      bus.wr_data = d;
      while (!bus.wr_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL push_timeout actual=wr_rdy_low expected=accept data=%h", d);
      end
      @(negedge clk);
      bus.wr_vld = 1'b0;
   endtask

   task automatic pop(input logic [47:0] e);
      exp_q.push_back(e);
      bus.pic_fifo_rd = 1'b1;
      @(negedge clk);
      bus.pic_fifo_rd = 1'b0;
   endtask

   task automatic frame_pulse();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      exp_fcrc  = model_crc;
      model_crc = 16'hFFFF;
`ifdef PIC_FIFO_CRC_EN
      chk("frame_crc", frame_crc, exp_fcrc);
`else
      chk("frame_crc_tied", frame_crc, 16'h0000);
`endif
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wr_rdy"}, bus.wr_rdy, 0);
      chk({tag, "_pic_rdy"}, bus.pic_rdy, 0);
      chk({tag, "_pic_data"}, bus.pic_data, 0);
      chk({tag, "_level"}, level, 0);
      chk({tag, "_underflow"}, underflow, 0);
      chk({tag, "_uf_cnt"}, underflow_cnt, 0);
      chk({tag, "_frame_crc"}, frame_crc, 0);
   endtask

   // Monitor: a pop issued before edge k must show its word just after edge k.
   initial begin
      logic        fire;
      logic [47:0] w;
      forever begin
         @(posedge clk);
         fire = bus.pic_fifo_rd;
         #1;
         if (fire) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pic_data_unexpected actual=%h expected=none", bus.pic_data);
            end else begin
               w = exp_q.pop_front();
               chk("pic_data", bus.pic_data, w);
               model_crc = ref_crc(model_crc, w);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.wr_vld      = 1'b0;
      bus.wr_data     = '0;
      bus.pic_fifo_rd = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;

      // 1: prime to 8 words, then in-order pops.
      pic_en = 1'b1;
      frame_pulse();
      chk("flush_wr_rdy", bus.wr_rdy, 0);
      for (int i = 1; i <= 8; i++) push(48'(i));
      chk("prime_level8", level, 8);
      chk("prime_rdy_low", bus.pic_rdy, 0);
      @(negedge clk);
      chk("stream_rdy", bus.pic_rdy, 1);
      for (int i = 1; i <= 8; i++) pop(48'(i));
      chk("t1_level0", level, 0);

      // 2: fill to 16, the 17th word waits for a pop.
      for (int i = 0; i < 16; i++) push(48'h10 + 48'(i));
      chk("full_level", level, 16);
      chk("full_wr_rdy", bus.wr_rdy, 0);
      bus.wr_vld  = 1'b1;
      bus.wr_data = 48'h20;
      repeat (2) @(negedge clk);
      chk("held_level", level, 16);
      exp_q.push_back(48'h10);
      bus.pic_fifo_rd = 1'b1;
      @(negedge clk);
      bus.pic_fifo_rd = 1'b0;
      chk("after_pop_wr_rdy", bus.wr_rdy, 1);
      chk("after_pop_level", level, 15);
      @(negedge clk);
      bus.wr_vld = 1'b0;
      chk("held_accepted", level, 16);
      for (int i = 1; i < 16; i++) pop(48'h10 + 48'(i));
      pop(48'h20);
      chk("t2_level0", level, 0);

      // 3: underflow on empty, then push+pop together on empty.
      repeat (3) pop(UFLOW);
      chk("uf_flag", underflow, 1);
      chk("uf_cnt3", underflow_cnt, 3);
      chk("uf_level", level, 0);
      bus.wr_vld      = 1'b1;
      bus.wr_data     = 48'hBB;
      exp_q.push_back(UFLOW);
      bus.pic_fifo_rd = 1'b1;
      @(negedge clk);
      bus.wr_vld      = 1'b0;
      bus.pic_fifo_rd = 1'b0;
      chk("nobypass_level", level, 1);
      chk("nobypass_cnt", underflow_cnt, 4);
      pop(48'hBB);
      chk("t3_level0", level, 0);

      // 4: new frame with 5 words buffered.
      for (int i = 1; i <= 5; i++) push(48'h30 + 48'(i));
      chk("pre_flush_level", level, 5);
      chk("uf_sticky", underflow, 1);
      frame_pulse();
      chk("flush_level", level, 0);
      chk("flush_pic_rdy", bus.pic_rdy, 0);
      chk("flush_uf", underflow, 0);
      chk("flush_uf_cnt", underflow_cnt, 0);
      for (int i = 1; i <= 7; i++) push(48'h40 + 48'(i));
      @(negedge clk);
      chk("reprime7_rdy", bus.pic_rdy, 0);
      push(48'h48);
      chk("reprime_level", level, 8);
      @(negedge clk);
      chk("reprime_rdy", bus.pic_rdy, 1);

      // 6: single zero word popped, then frame capture of the CRC.
      frame_pulse();
      push(48'h0);
      pop(48'h0);
      @(negedge clk);
      frame_pulse();

      // 5a: disable mid-PRIME.
      for (int i = 1; i <= 3; i++) push(48'h50 + 48'(i));
      chk("prime3_level", level, 3);
      pic_en = 1'b0;
      @(negedge clk);
      chk("dis_wr_rdy", bus.wr_rdy, 0);
      chk("dis_pic_rdy", bus.pic_rdy, 0);
      chk("dis_level", level, 0);

      // 5b: reset mid-STREAM with underflow set.
      pic_en = 1'b1;
      frame_pulse();
      for (int i = 1; i <= 8; i++) push(48'h60 + 48'(i));
      @(negedge clk);
      chk("s5_stream", bus.pic_rdy, 1);
      for (int i = 1; i <= 8; i++) pop(48'h60 + 48'(i));
      pop(UFLOW);
      chk("s5_uf", underflow, 1);
      chk("s5_uf_cnt", underflow_cnt, 1);
      push(48'h77);
      rst = 1'b1;
      @(negedge clk);
      model_crc = 16'hFFFF;
      chk_reset_outputs("midrst");
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_idle_wr_rdy", bus.wr_rdy, 0);

      repeat (2) @(negedge clk);
      chk("scoreboard_drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
